uart_mmio_fifo: RTL and testbench

//  Buffered bridge between the CPU memory-mapped IO port (addr space 0x8000_00xx) and the
//  on-chip uart. It decouples CPU stores and loads from UART byte timing.
//  - TX FIFO: accepts CPU byte stores and drives the uart transmitter handshake.
//  - RX FIFO: captures uart receiver bytes and returns them to CPU loads.
//  - Status/control word: FIFO levels and sticky overflow flags.

---
 rtl/uart_mmio_fifo.sv | 158 +++++++++++++++
 tb/tb_uart_mmio_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_fifo.sv
// uart_mmio_fifo: buffered bridge between the CPU MMIO port and the on-chip uart.
// A TX FIFO queues CPU byte stores for the transmitter, an RX FIFO queues received
// bytes for CPU loads, and a status/control word exposes FIFO levels and sticky
// overflow flags. Offsets: 0x0 STATUS/CTRL, 0x4 RX_DATA, 0x8 TX_DATA.
module uart_mmio_fifo #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mmio_addr,
  input  logic        mmio_we,
  input  logic        mmio_re,
  input  logic [31:0] mmio_wdata,
  output logic [31:0] mmio_rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  // Pointers carry one bit beyond the index so full and empty are distinguishable.
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_PW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_PW = RX_AW + 1;

  localparam logic [3:0] ADDR_CTRL = 4'h0;
  localparam logic [3:0] ADDR_RX   = 4'h4;
  localparam logic [3:0] ADDR_TX   = 4'h8;

  // Storage arrays (contents are not reset; pointers define validity).
  logic [7:0] tx_mem_q [TX_DEPTH];
  logic [7:0] rx_mem_q [RX_DEPTH];

  logic [TX_PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [RX_PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic             tx_ovf_q, tx_ovf_d;
  logic             rx_ovf_q, rx_ovf_d;
  logic             rx_stall_q, rx_stall_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [TX_PW-1:0] tx_count;
  logic [RX_PW-1:0] rx_count;
  logic [31:0]      tx_count_ext, rx_count_ext;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic             ctrl_wr, flush;
  logic             tx_push_req, tx_push, tx_pop, tx_ovf_set;
  logic             rx_push, rx_pop, rx_stall, rx_ovf_set;
  logic [7:0]       rx_head;
  logic [31:0]      status_word;
  logic             unused_bits;

  // Levels and flags decoded purely from registered pointers.
  assign tx_count = tx_wr_q - tx_rd_q;
  assign rx_count = rx_wr_q - rx_rd_q;
  assign tx_full  = (tx_count == TX_PW'(TX_DEPTH));
  assign rx_full  = (rx_count == RX_PW'(RX_DEPTH));
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign rx_empty = (rx_wr_q == rx_rd_q);

  assign tx_count_ext = 32'(tx_count);
  assign rx_count_ext = 32'(rx_count);

  // Handshake strobes; full/empty are pre-cycle state so a push into a full FIFO
  // is rejected even if a pop happens in the same cycle.
  assign ctrl_wr     = mmio_we && (mmio_addr == ADDR_CTRL);
  assign flush       = ctrl_wr && mmio_wdata[4];
  assign tx_push_req = mmio_we && (mmio_addr == ADDR_TX);
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_ovf_set  = tx_push_req && tx_full;
  assign tx_pop      = !tx_empty && uart_tx_ready;

  assign rx_push     = uart_rx_valid && !rx_full;
  assign rx_pop      = mmio_re && (mmio_addr == ADDR_RX) && !rx_empty;
  assign rx_stall    = rx_full && uart_rx_valid;
  assign rx_ovf_set  = mmio_re && rx_stall && rx_stall_q;

  assign rx_head = rx_mem_q[rx_rd_q[RX_AW-1:0]];

  assign status_word = {8'h00, rx_count_ext[7:0], tx_count_ext[7:0],
                        3'b000, tx_empty, rx_ovf_q, tx_ovf_q, !rx_empty, !tx_full};

  assign uart_tx_valid = !tx_empty;
  assign uart_tx_data  = tx_empty ? 8'h00 : tx_mem_q[tx_rd_q[TX_AW-1:0]];
  assign uart_rx_ready = !rx_full;
  assign mmio_rdata    = rdata_q;

  assign unused_bits = ^{mmio_wdata[31:8], tx_count_ext[31:8], rx_count_ext[31:8]};

  // Next-state for pointers, sticky flags and the registered load data.
  always_comb begin
    tx_wr_d    = tx_wr_q + TX_PW'(tx_push);
    tx_rd_d    = tx_rd_q + TX_PW'(tx_pop);
    rx_wr_d    = rx_wr_q + RX_PW'(rx_push);
    rx_rd_d    = rx_rd_q + RX_PW'(rx_pop);
    tx_ovf_d   = tx_ovf_q;
    rx_ovf_d   = rx_ovf_q;
    rx_stall_d = rx_stall;
    rdata_d    = rdata_q;

    if (flush) begin
      tx_wr_d = '0;
      tx_rd_d = '0;
      rx_wr_d = '0;
      rx_rd_d = '0;
    end

    if (ctrl_wr && mmio_wdata[2]) tx_ovf_d = 1'b0;
    if (ctrl_wr && mmio_wdata[3]) rx_ovf_d = 1'b0;
    if (tx_ovf_set) tx_ovf_d = 1'b1;
    if (rx_ovf_set) rx_ovf_d = 1'b1;

    if (mmio_re) begin
      case (mmio_addr)
        ADDR_CTRL: rdata_d = status_word;
        ADDR_RX:   rdata_d = rx_empty ? 32'h0 : {24'h0, rx_head};
        default:   rdata_d = 32'h0;
      endcase
    end
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      tx_ovf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
      rx_stall_q <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovf_q   <= rx_ovf_d;
      rx_stall_q <= rx_stall_d;
      rdata_q    <= rdata_d;
    end
  end

  // TX storage write on an accepted CPU store.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q[TX_AW-1:0]] <= mmio_wdata[7:0];
  end

  // RX storage write on an accepted receiver byte.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_q[RX_AW-1:0]] <= uart_rx_data;
  end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed self-checking bench for uart_mmio_fifo.
module tb_uart_mmio_fifo;

   logic        clk;
   logic        rst;
   logic [3:0]  mmio_addr;
   logic        mmio_we;
   logic        mmio_re;
   logic [31:0] mmio_wdata;
   logic [31:0] mmio_rdata;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_valid;
   logic        uart_tx_ready;
   logic [7:0]  uart_rx_data;
   logic        uart_rx_valid;
   logic        uart_rx_ready;

   int checkCount;
   int errorCount;

   uart_mmio_fifo #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .mmio_addr    (mmio_addr),
      .mmio_we      (mmio_we),
      .mmio_re      (mmio_re),
      .mmio_wdata   (mmio_wdata),
      .mmio_rdata   (mmio_rdata),
      .uart_tx_data (uart_tx_data),
      .uart_tx_valid(uart_tx_valid),
      .uart_tx_ready(uart_tx_ready),
      .uart_rx_data (uart_rx_data),
      .uart_rx_valid(uart_rx_valid),
      .uart_rx_ready(uart_rx_ready)
   );

   // 100 MHz free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value and count it
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock and land just after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of MMIO strobes; on a load, return the registered data
   task automatic applyStimulus(input logic we, input logic re, input logic [3:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rdata);
      mmio_we    = we;
      mmio_re    = re;
      mmio_addr  = addr;
      mmio_wdata = wdata;
      tick();
      mmio_we    = 1'b0;
      mmio_re    = 1'b0;
      rdata      = mmio_rdata;
   endtask

   function automatic logic [31:0] txView();
      return {23'h0, uart_tx_valid, uart_tx_data};
   endfunction

   logic [31:0] rd;

   // Directed test sequence
   initial begin
      checkCount    = 0;
      errorCount    = 0;
      rst           = 1'b0;
      mmio_addr     = 4'h0;
      mmio_we       = 1'b0;
      mmio_re       = 1'b0;
      mmio_wdata    = 32'h0;
      uart_tx_ready = 1'b0;
      uart_rx_data  = 8'h00;
      uart_rx_valid = 1'b0;

      // Reset state
      tick();
      tick();
      checkOutput("rst_txview", txView(), 32'h0);
      checkOutput("rst_rxready", {31'h0, uart_rx_ready}, 32'h1);
      checkOutput("rst_rdata", mmio_rdata, 32'h0);
      rst = 1'b1;
      tick();
      applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, rd);
      checkOutput("status_after_reset", rd, 32'h0000_0011);

      // TX ordering with transmitter always ready
      uart_tx_ready = 1'b1;
      applyStimulus(1'b1, 1'b0, 4'h8, 32'hFFFF_FF41, rd);
      checkOutput("tx_byte0", txView(), 32'h141);
      applyStimulus(1'b1, 1'b0, 4'h8, 32'h0000_1242, rd);
      checkOutput("tx_byte1", txView(), 32'h142);
      applyStimulus(1'b1, 1'b0, 4'h8, 32'h0000_0043, rd);
      checkOutput("tx_byte2", txView(), 32'h143);
      tick();
      checkOutput("tx_drained", txView(), 32'h0);

      // TX overflow and clear
      uart_tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 4'h8, 32'h50 + i, rd);
      applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, rd);
      checkOutput("status_tx_ovf", rd, 32'h0000_0804);
      checkOutput("tx_head_full", txView(), 32'h150);
      applyStimulus(1'b1, 1'b0, 4'h0, 32'h4, rd);
      applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, rd);
      checkOutput("status_tx_ovf_clr", rd, 32'h0000_0800);

      // RX fill then drain
      uart_rx_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         uart_rx_data = 8'h10 + 8'(i);
         tick();
      end
      uart_rx_valid = 1'b0;
      checkOutput("rx_ready_full", {31'h0, uart_rx_ready}, 32'h0);
      applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, rd);
      checkOutput("status_rx_full", rd, 32'h0008_0802);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b1, 4'h4, 32'h0, rd);
         checkOutput($sformatf("rx_read%0d", i), rd, 32'h10 + i);
      end
      applyStimulus(1'b0, 1'b1, 4'h4, 32'h0, rd);
      checkOutput("rx_read_empty", rd, 32'h0);
      applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, rd);
      checkOutput("status_rx_empty", rd, 32'h0000_0800);

      // TX simultaneous push/pop at count 7 and at full
      uart_tx_ready = 1'b1;
      tick();
      uart_tx_ready = 1'b0;
      uart_tx_ready = 1'b1;
      applyStimulus(1'b1, 1'b0, 4'h8, 32'h60, rd);
      uart_tx_ready = 1'b0;
      applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, rd);
      checkOutput("status_pushpop7", rd, 32'h0000_0701);
      checkOutput("tx_head_after_pops", txView(), 32'h152);
      applyStimulus(1'b1, 1'b0, 4'h8, 32'h61, rd);
      uart_tx_ready = 1'b1;
      applyStimulus(1'b1, 1'b0, 4'h8, 32'h62, rd);
      uart_tx_ready = 1'b0;
      applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, rd);
      checkOutput("status_pushpop_full", rd, 32'h0000_0705);
      checkOutput("tx_head_after_full", txView(), 32'h153);

      // RX to count 5, then rdata hold and unmapped load
      uart_rx_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         uart_rx_data = 8'h20 + 8'(i);
         tick();
      end
      uart_rx_valid = 1'b0;
      applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, rd);
      checkOutput("status_rx5", rd, 32'h0005_0707);
      tick();
      tick();
      checkOutput("rdata_hold", mmio_rdata, 32'h0005_0707);
      applyStimulus(1'b0, 1'b1, 4'hC, 32'h0, rd);
      checkOutput("unmapped_load", rd, 32'h0);

      // Asynchronous reset mid-stream
      #3;
      rst = 1'b0;
      #1;
      checkOutput("async_rx_ready", {31'h0, uart_rx_ready}, 32'h1);
      checkOutput("async_tx_view", txView(), 32'h0);
      tick();
      tick();
      rst = 1'b1;
      applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, rd);
      checkOutput("status_after_async", rd, 32'h0000_0011);

      // Flush both FIFOs through CTRL
      applyStimulus(1'b1, 1'b0, 4'h8, 32'h70, rd);
      applyStimulus(1'b1, 1'b0, 4'h8, 32'h71, rd);
      uart_rx_valid = 1'b1;
      uart_rx_data  = 8'h33;
      tick();
      uart_rx_valid = 1'b0;
      applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, rd);
      checkOutput("status_pre_flush", rd, 32'h0001_0203);
      applyStimulus(1'b1, 1'b0, 4'h0, 32'h10, rd);
      applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, rd);
      checkOutput("status_post_flush", rd, 32'h0000_0011);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
